// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack instruction memory read, IR valid/ready hand-off,
// jump redirect and HALT stop. Optional FETCH_PERF_CNT_EN adds a saturating fetch_count.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [4:0]        HALT_OP  = 5'd31
) (
    input  logic               clock,
    input  logic               system_reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [ADDR_W-1:0]  pc_of_ir,
    input  logic               jump_valid,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               restart,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

    state_t               state_r, state_s;
    logic [ADDR_W-1:0]    pc_r, pc_s;
    logic [INSTR_W-1:0]   ir_r, ir_s;
    logic [ADDR_W-1:0]    pc_of_ir_r, pc_of_ir_s;
    logic                 ir_valid_r, ir_valid_s;
    logic                 halted_r, halted_s;
    logic                 req_r, req_s;
    logic                 handshake_s;

    assign handshake_s = ir_valid_r & ir_ready;

    // Next-state and datapath update; a jump overrides every state and always
    // passes through IDLE so the memory request is dropped for at least one cycle.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        pc_of_ir_s = pc_of_ir_r;
        ir_valid_s = ir_valid_r;
        halted_s   = halted_r;
        case (state_r)
            IDLE: begin
                state_s = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    ir_s       = imem_rdata;
                    pc_of_ir_s = pc_r;
                    pc_s       = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    ir_valid_s = 1'b1;
                    state_s    = HOLD;
                end else begin
                    state_s = REQ;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    ir_valid_s = 1'b0;
                    if (ir_r[INSTR_W-1 -: 5] == HALT_OP) begin
                        halted_s = 1'b1;
                        state_s  = HALT;
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            HALT: begin
                if (restart) begin
                    halted_s = 1'b0;
                    state_s  = REQ;
                end else begin
                    state_s = HALT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A word acked in the jump cycle is discarded, so ir/pc_of_ir keep their value.
        if (jump_valid) begin
            pc_s       = jump_addr;
            ir_s       = ir_r;
            pc_of_ir_s = pc_of_ir_r;
            ir_valid_s = 1'b0;
            halted_s   = 1'b0;
            state_s    = IDLE;
        end else begin
            state_s = state_s;
        end
        req_s = (state_s == REQ);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            ir_r       <= {INSTR_W{1'b0}};
            pc_of_ir_r <= {ADDR_W{1'b0}};
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            pc_of_ir_r <= pc_of_ir_s;
            ir_valid_r <= ir_valid_s;
            halted_r   <= halted_s;
            req_r      <= req_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign ir        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign pc_of_ir  = pc_of_ir_r;
    assign halted    = halted_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;

    // Accepted-instruction counter, saturating at all-ones.
    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            fetch_count_r <= 32'd0;
        end else if (handshake_s && (fetch_count_r != 32'hFFFF_FFFF)) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`endif

endmodule
